// File: rtl/regbank_pkg.sv
// Shared constants and types for the register-bank selection logic.
// Pure declarations: no latency, no backpressure.
// Holds register count, select width, default word width and the select type.
package regbank_pkg;

    localparam int NUM_REGS  = 16;
    localparam int SEL_W     = 4;
    localparam int DEF_WIDTH = 32;

    typedef logic [SEL_W-1:0] reg_sel_t;

endpackage : regbank_pkg

// File: rtl/word_mux16.sv
// word_mux16: 16:1 word multiplexer, one instance per register-bank read port.
// Latency: combinational, output follows inputs in the same cycle.
// Backpressure: none, no handshake; an unknown select yields an all-zero word.
//
// Ports:
//   d0..d15 : candidate words, entry 0..15
//   sel     : entry number to pass through
//   y       : selected word (zero when sel is not a known value)
module word_mux16
    import regbank_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic [WIDTH-1:0] d4,
    input  logic [WIDTH-1:0] d5,
    input  logic [WIDTH-1:0] d6,
    input  logic [WIDTH-1:0] d7,
    input  logic [WIDTH-1:0] d8,
    input  logic [WIDTH-1:0] d9,
    input  logic [WIDTH-1:0] d10,
    input  logic [WIDTH-1:0] d11,
    input  logic [WIDTH-1:0] d12,
    input  logic [WIDTH-1:0] d13,
    input  logic [WIDTH-1:0] d14,
    input  logic [WIDTH-1:0] d15,
    input  reg_sel_t         sel,
    output logic [WIDTH-1:0] y
);

    // A select carrying X/Z matches no item and falls into the default,
    // so downstream logic sees a clean zero word instead of X.
    always_comb begin
        y = '0;
        case (sel)
            4'd0:    y = d0;
            4'd1:    y = d1;
            4'd2:    y = d2;
            4'd3:    y = d3;
            4'd4:    y = d4;
            4'd5:    y = d5;
            4'd6:    y = d6;
            4'd7:    y = d7;
            4'd8:    y = d8;
            4'd9:    y = d9;
            4'd10:   y = d10;
            4'd11:   y = d11;
            4'd12:   y = d12;
            4'd13:   y = d13;
            4'd14:   y = d14;
            4'd15:   y = d15;
            default: y = '0;
        endcase
    end

endmodule : word_mux16

// File: rtl/regbank_select_unit.sv
// regbank_select_unit: two 16:1 read muxes plus a 4-to-16 one-hot write decoder.
// Latency: combinational, zero cycles; no clock and no storage.
// Backpressure: none; rst (async, active-high) only forces wr_onehot to zero.
//
// Ports:
//   rst        : forces all write enables low while high; reads unaffected
//   rd_sel_a/b : register numbers for read ports A and B
//   wr_sel     : destination register number
//   wr_en      : write-decoder enable (bank normally ties it high)
//   r0..r15    : current register contents
//   rd_data_a/b: selected words for ports A and B
//   wr_onehot  : per-register load enable, bit k loads register k
module regbank_select_unit
    import regbank_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                rst,
    input  reg_sel_t            rd_sel_a,
    input  reg_sel_t            rd_sel_b,
    input  reg_sel_t            wr_sel,
    input  logic                wr_en,
    input  logic [WIDTH-1:0]    r0,
    input  logic [WIDTH-1:0]    r1,
    input  logic [WIDTH-1:0]    r2,
    input  logic [WIDTH-1:0]    r3,
    input  logic [WIDTH-1:0]    r4,
    input  logic [WIDTH-1:0]    r5,
    input  logic [WIDTH-1:0]    r6,
    input  logic [WIDTH-1:0]    r7,
    input  logic [WIDTH-1:0]    r8,
    input  logic [WIDTH-1:0]    r9,
    input  logic [WIDTH-1:0]    r10,
    input  logic [WIDTH-1:0]    r11,
    input  logic [WIDTH-1:0]    r12,
    input  logic [WIDTH-1:0]    r13,
    input  logic [WIDTH-1:0]    r14,
    input  logic [WIDTH-1:0]    r15,
    output logic [WIDTH-1:0]    rd_data_a,
    output logic [WIDTH-1:0]    rd_data_b,
    output logic [NUM_REGS-1:0] wr_onehot
);

    logic [NUM_REGS-1:0] w_onehot;

    word_mux16 #(.WIDTH(WIDTH)) u_mux_a (
        .d0 (r0),  .d1 (r1),  .d2 (r2),  .d3 (r3),
        .d4 (r4),  .d5 (r5),  .d6 (r6),  .d7 (r7),
        .d8 (r8),  .d9 (r9),  .d10(r10), .d11(r11),
        .d12(r12), .d13(r13), .d14(r14), .d15(r15),
        .sel(rd_sel_a),
        .y  (rd_data_a)
    );

    word_mux16 #(.WIDTH(WIDTH)) u_mux_b (
        .d0 (r0),  .d1 (r1),  .d2 (r2),  .d3 (r3),
        .d4 (r4),  .d5 (r5),  .d6 (r6),  .d7 (r7),
        .d8 (r8),  .d9 (r9),  .d10(r10), .d11(r11),
        .d12(r12), .d13(r13), .d14(r14), .d15(r15),
        .sel(rd_sel_b),
        .y  (rd_data_b)
    );

    // Equality-compare decode: an X/Z bit in wr_sel makes every compare
    // non-true, so no enable fires. rst is purely combinational gating,
    // which is what makes it take effect without a clock and release
    // with no recovery cycle.
    always_comb begin
        w_onehot = '0;
        if (!rst && wr_en) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (wr_sel == reg_sel_t'(k)) begin
                    w_onehot[k] = 1'b1;
                end
            end
        end
    end

    assign wr_onehot = w_onehot;

endmodule : regbank_select_unit

// File: tb/tb_regbank_select_unit.sv
// Directed self-checking bench for regbank_select_unit.
// Inputs change on the rising edge of a pacing clock, outputs are checked on the falling edge.
// The design is combinational; the clock only paces stimulus and sampling.
module tb_regbank_select_unit;

    import regbank_pkg::*;

    localparam int W = 32;

    logic        tb_clk = 1'b0;
    logic        rst;
    reg_sel_t    rd_sel_a, rd_sel_b, wr_sel;
    logic        wr_en;
    logic [W-1:0] r [16];
    logic [W-1:0] rd_data_a, rd_data_b;
    logic [15:0]  wr_onehot;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 tb_clk = ~tb_clk;

    regbank_select_unit #(.WIDTH(W)) dut (
        .rst      (rst),
        .rd_sel_a (rd_sel_a),
        .rd_sel_b (rd_sel_b),
        .wr_sel   (wr_sel),
        .wr_en    (wr_en),
        .r0 (r[0]),  .r1 (r[1]),  .r2 (r[2]),  .r3 (r[3]),
        .r4 (r[4]),  .r5 (r[5]),  .r6 (r[6]),  .r7 (r[7]),
        .r8 (r[8]),  .r9 (r[9]),  .r10(r[10]), .r11(r[11]),
        .r12(r[12]), .r13(r[13]), .r14(r[14]), .r15(r[15]),
        .rd_data_a(rd_data_a),
        .rd_data_b(rd_data_b),
        .wr_onehot(wr_onehot)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic settle();
        @(negedge tb_clk);
    endtask

    task automatic drive_edge();
        @(posedge tb_clk);
    endtask

    logic       xprobe;
    logic       four_state;
    logic [3:0] sel_tmp;
    logic [15:0] exp_oh;

    initial begin
        // Detect whether the simulator keeps X/Z; the unknown-select checks
        // only mean something when it does.
        xprobe     = 1'bx;
        four_state = (xprobe === 1'bx);

        rst      = 1'b1;
        wr_en    = 1'b1;
        wr_sel   = 4'd5;
        rd_sel_a = 4'd0;
        rd_sel_b = 4'd0;
        for (int k = 0; k < 16; k++) r[k] = 32'hA500_0000 + k;
        settle();
        chk("reset_onehot", {16'h0, wr_onehot}, 32'h0);
        chk("reset_rd_a", rd_data_a, 32'hA500_0000);

        drive_edge();
        rst = 1'b0;
        settle();
        chk("post_reset_onehot", {16'h0, wr_onehot}, 32'h0000_0020);

        // Read sweep: port B mirrors port A.
        for (int s = 0; s < 16; s++) begin
            drive_edge();
            rd_sel_a = 4'(s);
            rd_sel_b = 4'(15 - s);
            settle();
            chk($sformatf("sweep_a%0d", s), rd_data_a, 32'hA500_0000 + s);
            chk($sformatf("sweep_b%0d", s), rd_data_b, 32'hA500_0000 + (15 - s));
        end

        // Same entry on both ports, then the entry changes under them.
        drive_edge();
        rd_sel_a = 4'd7;
        rd_sel_b = 4'd7;
        r[7]     = 32'hDEAD_BEEF;
        settle();
        chk("same_a", rd_data_a, 32'hDEAD_BEEF);
        chk("same_b", rd_data_b, 32'hDEAD_BEEF);
        r[7] = 32'h0;
        #1;
        chk("follow_a", rd_data_a, 32'h0);
        chk("follow_b", rd_data_b, 32'h0);
        r[7] = 32'hA500_0007;

        // Decoder sweep.
        for (int s = 0; s < 16; s++) begin
            drive_edge();
            wr_en  = 1'b1;
            wr_sel = 4'(s);
            settle();
            exp_oh = 16'h0001 << s;
            chk($sformatf("dec%0d", s), {16'h0, wr_onehot}, {16'h0, exp_oh});
            chk($sformatf("dec_ones%0d", s), 32'($countones(wr_onehot)), 32'd1);
        end

        // Enable gating.
        drive_edge();
        wr_en  = 1'b0;
        wr_sel = 4'd9;
        settle();
        chk("en_off", {16'h0, wr_onehot}, 32'h0);
        wr_en = 1'b1;
        #1;
        chk("en_on", {16'h0, wr_onehot}, 32'h0000_0200);

        // Async reset mid-operation, no clock edge between steps.
        drive_edge();
        wr_sel   = 4'd3;
        rd_sel_a = 4'd4;
        rd_sel_b = 4'd11;
        settle();
        chk("pre_rst_onehot", {16'h0, wr_onehot}, 32'h0000_0008);
        #1 rst = 1'b1;
        #1;
        chk("rst_onehot", {16'h0, wr_onehot}, 32'h0);
        chk("rst_rd_a", rd_data_a, 32'hA500_0004);
        chk("rst_rd_b", rd_data_b, 32'hA500_000B);
        #1 rst = 1'b0;
        #1;
        chk("rel_onehot", {16'h0, wr_onehot}, 32'h0000_0008);

        // Unknown selects.
        drive_edge();
        sel_tmp  = 4'bxx01;
        rd_sel_a = sel_tmp;
        sel_tmp  = 4'bz000;
        wr_sel   = sel_tmp;
        settle();
        if (four_state) begin
            chk("x_rd_a", rd_data_a, 32'h0);
            chk("z_onehot", {16'h0, wr_onehot}, 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_regbank_select_unit

// File: doc/regbank_select_unit.md
Name: regbank_select_unit

Overview:
- Combinational selection front-end for the 16-entry x 32-bit register bank.
- Provides two independent 16:1 word read multiplexers, one for each read port (A and B).
- Provides one 4-to-16 one-hot write-select decoder that drives per-register load enables.
- Sits between the instruction decode fields (source/destination register numbers) and the register storage. It holds no storage.

Parameters:
- WIDTH, 32, bit width of each register word and of each read-data output.

Ports:
- rst  in  1  asynchronous active-high reset; forces all write enables low while asserted.
- rd_sel_a  in  4  register number for read port A.
- rd_sel_b  in  4  register number for read port B.
- wr_sel  in  4  destination register number.
- wr_en  in  1  write-decoder enable; the bank normally ties it high.
- r0 .. r15  in  WIDTH each  current register contents, entry 0 .. 15.
- rd_data_a  out  WIDTH  word of entry rd_sel_a.
- rd_data_b  out  WIDTH  word of entry rd_sel_b.
- wr_onehot  out  16  one-hot load enable; bit k selects register k.

Behaviour:
- Fully combinational. Zero latency: outputs follow inputs within the same delta/cycle. No clock.
- Read port A: rd_data_a = r[rd_sel_a], selecting r0 for 0 through r15 for 15.
- Read port B: identical, independent, driven by rd_sel_b.
- Both read ports may select the same entry; both then return that word.
- Read outputs are not affected by rst. They always reflect the inputs.
- If a read select contains X/Z, the corresponding read output is all-zero (default branch).
- Write decoder, normal operation: when rst=0 and wr_en=1, wr_onehot = 1 << wr_sel. Exactly one bit is set.
- Write decoder, disabled: when wr_en=0, wr_onehot = 16'h0000.
- Write decoder, reset: while rst=1, wr_onehot = 16'h0000, asynchronously and regardless of wr_en or wr_sel.
- After rst deasserts, wr_onehot immediately re-reflects wr_en and wr_sel. No recovery cycle.
- wr_sel containing X/Z drives wr_onehot = 16'h0000.
- wr_sel=0 asserts bit 0. Keeping r0 hard-wired to zero is the register bank's job, not this block's.
- No width conversion: each read output is exactly WIDTH bits, passed unmodified.
- Reset values: wr_onehot = 0 during reset. rd_data_a and rd_data_b carry no reset value because they are pure functions of r0..r15.

Decomposition:
- Shared package regbank_pkg holds:
  - NUM_REGS = 16
  - SEL_W = 4
  - default WIDTH = 32
  - typedef reg_sel_t (logic [SEL_W-1:0])
- Sub-module word_mux16: a WIDTH-parameterised 16:1 word multiplexer with inputs d0..d15 and sel, and output y. It is instantiated twice, once per read port.
- The decoder is small enough to stay inline in regbank_select_unit.

Test Plan:
- Read sweep: drive r_k = 32'hA5000000 + k. Sweep rd_sel_a over 0..15 with rd_sel_b = 15 - rd_sel_a. Require rd_data_a = 32'hA5000000 + rd_sel_a and rd_data_b = 32'hA5000000 + (15 - rd_sel_a) at every step.
- Same-entry read: rd_sel_a = rd_sel_b = 7 with r7 = 32'hDEADBEEF. Require both outputs = 32'hDEADBEEF. Then change r7 to 32'h0 and require both outputs to follow immediately.
- Decoder sweep: rst=0, wr_en=1, wr_sel = 0..15. Require wr_onehot = 16'h0001, 16'h0002, ..., 16'h8000, with exactly one bit set each time.
- Enable gating: wr_en=0 with wr_sel=9. Require wr_onehot = 16'h0000. Raise wr_en to 1 and require 16'h0200.
- Async reset: wr_en=1, wr_sel=3 gives 16'h0008. Assert rst mid-operation and require wr_onehot = 16'h0000 with no clock applied, while rd_data_a/rd_data_b remain unchanged. Deassert rst and require 16'h0008 again.
- Unknown select: rd_sel_a = 4'bxx01 and wr_sel = 4'bz000. Require rd_data_a = 32'h0 and wr_onehot = 16'h0000.
